// File: rtl/mii_rx_pkg.sv
// mii_rx_pkg: shared error codes, CRC-32 constants, MII nibble values and FSM state encoding.
package mii_rx_pkg;
    localparam logic [2:0] ERR_OK     = 3'd0;
    localparam logic [2:0] ERR_CRC    = 3'd1;
    localparam logic [2:0] ERR_SHORT  = 3'd2;
    localparam logic [2:0] ERR_LONG   = 3'd3;
    localparam logic [2:0] ERR_ALIGN  = 3'd4;
    localparam logic [2:0] ERR_PHYERR = 3'd5;
    localparam logic [2:0] ERR_NOSFD  = 3'd6;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    localparam logic [3:0] PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB      = 4'hD;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        PREAMBLE,
        DATA,
        DROP,
        DONE
    } state_t;
endpackage

// File: rtl/mii_rx_frame_checker_crc32_nibble.sv
// crc32_nibble: combinational reflected CRC-32 update by one nibble, LSB first.
module crc32_nibble
    import mii_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [3:0]  nib,
    output logic [31:0] crc_out
);
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 4; i++)
            crc_out = (crc_out >> 1) ^ ((crc_out[0] ^ nib[i]) ? CRC32_POLY_REFL : 32'h0);
    end
endmodule

// File: rtl/mii_rx_frame_checker.sv
// mii_rx_frame_checker: MII receive passthrough with preamble/SFD parsing, CRC-32, length/alignment checks.
// Define RX_FRAME_STATS_EN to add saturating good_cnt/bad_cnt frame counters.
module mii_rx_frame_checker
    import mii_rx_pkg::*;
#(
    parameter int MIN_NIBBLES = 128,
    parameter int MAX_NIBBLES = 338
) (
    input  logic        phy_rxclk,
    input  logic        rst,
    input  logic [3:0]  phy_rxd,
    input  logic        phy_rxen,
    input  logic        phy_rxer,
    output logic [3:0]  chk_rxd,
    output logic        chk_rxen,
    output logic        chk_rxer,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [2:0]  err_code,
`ifdef RX_FRAME_STATS_EN
    output logic [8:0]  frame_len,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
`else
    output logic [8:0]  frame_len
`endif
);
    localparam logic [8:0] MIN_LEN = 9'(MIN_NIBBLES);
    localparam logic [8:0] MAX_LEN = 9'(MAX_NIBBLES);

    state_t      state, state_nx;
    logic [2:0]  code, code_nx, fin_code;
    logic [8:0]  len;
    logic [31:0] crc, crc_upd;

    crc32_nibble u_crc (.crc_in(crc), .nib(phy_rxd), .crc_out(crc_upd));

    always_comb begin
        state_nx = state;
        code_nx  = code;
        case (state)
            WAIT_IDLE: state_nx = phy_rxen ? WAIT_IDLE : IDLE;
            IDLE: if (phy_rxen) begin
                state_nx = (phy_rxd == PREAMBLE_NIB) ? PREAMBLE : DROP;
                code_nx  = (phy_rxd == PREAMBLE_NIB) ? ERR_OK : ERR_NOSFD;
            end
            PREAMBLE: if (!phy_rxen) begin
                state_nx = DONE;
                code_nx  = ERR_NOSFD;
            end else if (phy_rxd == SFD_NIB) begin
                state_nx = DATA;
            end else if (phy_rxd != PREAMBLE_NIB) begin
                state_nx = DROP;
                code_nx  = ERR_NOSFD;
            end
            DATA: if (!phy_rxen) begin
                state_nx = DONE;
            end else if (len == MAX_LEN) begin
                state_nx = DROP;
                code_nx  = ERR_LONG;
            end
            DROP: state_nx = phy_rxen ? DROP : DONE;
            DONE: begin
                state_nx = (phy_rxen && phy_rxd == PREAMBLE_NIB) ? PREAMBLE : IDLE;
                code_nx  = ERR_OK;
            end
            default: state_nx = WAIT_IDLE;
        endcase
        if (state != WAIT_IDLE && phy_rxen && phy_rxer) begin
            state_nx = DROP;
            code_nx  = ERR_PHYERR;
        end
    end

    // Latched codes already outrank every check made at end of frame.
    always_comb
        fin_code = (code != ERR_OK)          ? code      :
                   len[0]                    ? ERR_ALIGN :
                   (len < MIN_LEN)           ? ERR_SHORT :
                   (crc != CRC32_RESIDUE)    ? ERR_CRC   : ERR_OK;

    always_ff @(posedge phy_rxclk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_IDLE;
            code      <= ERR_OK;
            len       <= '0;
            crc       <= '1;
            chk_rxd   <= '0;
            chk_rxen  <= 1'b0;
            chk_rxer  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= '0;
            frame_len <= '0;
        end else begin
            state     <= state_nx;
            code      <= code_nx;
            chk_rxd   <= phy_rxd;
            chk_rxen  <= phy_rxen;
            chk_rxer  <= phy_rxer | (state_nx == DROP);
            crc       <= (state == PREAMBLE && phy_rxen && phy_rxd == SFD_NIB) ? '1 :
                         (state == DATA && phy_rxen) ? crc_upd : crc;
            len       <= (state == IDLE || state == DONE) ? '0 :
                         (state == DATA && phy_rxen) ? len + 9'd1 : len;
            frame_ok  <= state == DONE && fin_code == ERR_OK;
            frame_err <= state == DONE && fin_code != ERR_OK;
            err_code  <= (state == DONE) ? fin_code : err_code;
            frame_len <= (state == DONE) ? len : frame_len;
        end
    end

`ifdef RX_FRAME_STATS_EN
    always_ff @(posedge phy_rxclk or posedge rst) begin
        if (rst) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            good_cnt <= (frame_ok && !(&good_cnt)) ? good_cnt + 16'd1 : good_cnt;
            bad_cnt  <= (frame_err && !(&bad_cnt)) ? bad_cnt + 16'd1 : bad_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_mii_rx_frame_checker.sv
// tb_mii_rx_frame_checker: directed frames scored by a frame-level model of the receive checks.
module tb_mii_rx_frame_checker;
    localparam int MINN = 128;
    localparam int MAXN = 338;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  phy_rxd = 4'h0;
    logic        phy_rxen = 1'b0;
    logic        phy_rxer = 1'b0;
    logic [3:0]  chk_rxd;
    logic        chk_rxen, chk_rxer, frame_ok, frame_err;
    logic [2:0]  err_code;
    logic [8:0]  frame_len;
`ifdef RX_FRAME_STATS_EN
    logic [15:0] good_cnt, bad_cnt;
`endif

    mii_rx_frame_checker dut (
        .phy_rxclk(clk),
        .rst(rst),
        .phy_rxd(phy_rxd),
        .phy_rxen(phy_rxen),
        .phy_rxer(phy_rxer),
        .chk_rxd(chk_rxd),
        .chk_rxen(chk_rxen),
        .chk_rxer(chk_rxer),
        .frame_ok(frame_ok),
        .frame_err(frame_err),
        .err_code(err_code),
`ifdef RX_FRAME_STATS_EN
        .frame_len(frame_len),
        .good_cnt(good_cnt),
        .bad_cnt(bad_cnt)
`else
        .frame_len(frame_len)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0, v_at = -1;
    int ok_seen = 0, err_seen = 0, exp_good = 0, exp_bad = 0;
    logic [2:0] v_code = '0, hold_code = '0;
    logic [8:0] v_len = '0, hold_len = '0;
    logic       exp_drop = 1'b0;
    logic [3:0] nq[$];
    int         er_at = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] crc32(input logic [7:0] b[$]);
        logic [31:0] c = '1;
        foreach (b[i]) begin
            c ^= {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Preamble, SFD, ndata payload bytes, FCS; optionally one bit flipped after the FCS is computed.
    task automatic build(input int ndata, input int flip);
        logic [7:0]  b[$];
        logic [31:0] f;
        nq.delete();
        er_at = -1;
        for (int i = 0; i < ndata; i++) b.push_back(8'(i * 37 + 11));
        f = crc32(b);
        for (int i = 0; i < 4; i++) b.push_back(f[8*i +: 8]);
        if (flip >= 0) b[flip / 8] ^= 8'(1 << (flip % 8));
        repeat (15) nq.push_back(4'h5);
        nq.push_back(4'hD);
        foreach (b[i]) begin
            nq.push_back(b[i][3:0]);
            nq.push_back(b[i][7:4]);
        end
    endtask

    task automatic drive(input logic [3:0] d, input logic en, input logic er, input logic dr);
        @(negedge clk);
        phy_rxd  = d;
        phy_rxen = en;
        phy_rxer = er;
        exp_drop = dr;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Frame-level verdict: where dropping starts, which error wins, how many nibbles count.
    task automatic run_frame(input int ifg);
        int s, d, n, len;
        logic sfd, crc_ok;
        logic [2:0] code;
        logic [7:0] db[$];
        logic [31:0] fcs;
        s = 0;
        while (s < nq.size() && nq[s] == 4'h5) s++;
        sfd = s > 0 && s < nq.size() && nq[s] == 4'hD;
        d = nq.size();
        if (s < nq.size() && !sfd) d = s;
        n = sfd ? nq.size() - s - 1 : 0;
        if (sfd && n > MAXN) d = s + 1 + MAXN;
        if (er_at >= 0 && er_at < d) d = er_at;
        len = (!sfd || d <= s) ? 0 : ((d - s) < n ? d - s : n);
        crc_ok = 1'b0;
        if (sfd && n % 2 == 0 && n >= MINN && n <= MAXN) begin
            for (int j = 0; j < n / 2; j++) db.push_back({nq[s + 2 + 2*j], nq[s + 1 + 2*j]});
            fcs = {db[n/2 - 1], db[n/2 - 2], db[n/2 - 3], db[n/2 - 4]};
            repeat (4) void'(db.pop_back());
            crc_ok = crc32(db) == fcs;
        end
        code = (er_at >= 0) ? 3'd5 : !sfd ? 3'd6 : (n > MAXN) ? 3'd3 :
               (n % 2 == 1) ? 3'd4 : (n < MINN) ? 3'd2 : !crc_ok ? 3'd1 : 3'd0;
        for (int i = 0; i < nq.size(); i++) drive(nq[i], 1'b1, i == er_at, i >= d);
        v_code = code;
        v_len  = 9'(len);
        v_at   = cyc + 3;
        idle(ifg);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    always @(posedge clk) begin
        logic hit;
        cyc++;
        #2;
        hit = !rst && cyc == v_at;
        if (rst) begin
            hold_code = '0;
            hold_len  = '0;
            exp_good  = 0;
            exp_bad   = 0;
        end
        if (hit) begin
            hold_code = v_code;
            hold_len  = v_len;
        end
        chk("chk_rxd", 32'(chk_rxd), rst ? 32'd0 : 32'(phy_rxd));
        chk("chk_rxen", 32'(chk_rxen), rst ? 32'd0 : 32'(phy_rxen));
        chk("chk_rxer", 32'(chk_rxer), rst ? 32'd0 : 32'(phy_rxer | exp_drop));
        chk("frame_ok", 32'(frame_ok), 32'(hit && v_code == 3'd0));
        chk("frame_err", 32'(frame_err), 32'(hit && v_code != 3'd0));
        chk("err_code", 32'(err_code), 32'(hold_code));
        chk("frame_len", 32'(frame_len), 32'(hold_len));
`ifdef RX_FRAME_STATS_EN
        chk("good_cnt", 32'(good_cnt), 32'(exp_good));
        chk("bad_cnt", 32'(bad_cnt), 32'(exp_bad));
`endif
        if (hit) begin
            exp_good += (v_code == 3'd0) ? 1 : 0;
            exp_bad  += (v_code != 3'd0) ? 1 : 0;
        end
        ok_seen  += frame_ok ? 1 : 0;
        err_seen += frame_err ? 1 : 0;
    end

    initial begin
        logic [7:0] q9[$];
        for (int i = 0; i < 9; i++) q9.push_back(8'(8'h31 + i));
        chk("model_crc_check_value", crc32(q9), 32'hCBF43926);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(4);

        build(60, -1); run_frame(8);
        chk("t1_code", 32'(err_code), 32'd0);
        chk("t1_len", 32'(frame_len), 32'd128);

        build(60, 83); run_frame(8);
        chk("t2_code", 32'(err_code), 32'd1);
        chk("t2_len", 32'(frame_len), 32'd128);

        build(56, -1); run_frame(8);
        chk("t3_short_code", 32'(err_code), 32'd2);
        chk("t3_short_len", 32'(frame_len), 32'd120);

        build(166, -1); run_frame(8);
        chk("t3_long_code", 32'(err_code), 32'd3);
        chk("t3_long_len", 32'(frame_len), 32'd339);

        build(60, -1); er_at = 16 + 39; run_frame(8);
        chk("t4_phyerr_code", 32'(err_code), 32'd5);

        build(60, -1); nq.push_back(4'h0); run_frame(8);
        chk("t4_align_code", 32'(err_code), 32'd4);
        chk("t4_align_len", 32'(frame_len), 32'd129);

        nq.delete(); er_at = -1;
        repeat (7) nq.push_back(4'h5);
        nq.push_back(4'hA);
        repeat (8) nq.push_back(4'h3);
        run_frame(8);
        chk("nosfd_code", 32'(err_code), 32'd6);
        chk("nosfd_len", 32'(frame_len), 32'd0);

        build(60, -1);
        for (int i = 0; i < nq.size(); i++) begin
            drive(nq[i], 1'b1, 1'b0, 1'b0);
            if (i == 16 + 49) rst = 1'b1;
            if (i == 16 + 51) rst = 1'b0;
        end
        idle(8);
        chk("t5_no_verdict_code", 32'(err_code), 32'd0);
        build(60, -1); run_frame(8);
        chk("t5_after_code", 32'(err_code), 32'd0);

        do_reset();
        build(60, -1); run_frame(24);
        build(60, -1); run_frame(24);
`ifdef RX_FRAME_STATS_EN
        chk("t6_good_cnt", 32'(good_cnt), 32'd2);
        chk("t6_bad_cnt", 32'(bad_cnt), 32'd0);
`endif
        chk("ok_pulses", 32'(ok_seen), 32'd4);
        chk("err_pulses", 32'(err_seen), 32'd6);
        idle(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
